// File: rtl/disk_page_responder.sv
// Disk-side page responder: moves one page of words between a valid/ready word
// stream and a synchronous-read disk port, in a direction fixed per request.
module disk_page_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned PAGE_WORDS = 1024,
    parameter int unsigned PAGE_W     = ADDR_W - $clog2(PAGE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              dir,
    input  logic [PAGE_W-1:0] page,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_s,
    output logic [ADDR_W-1:0] addr_s,
    output logic              tr_s,
    input  logic [DATA_W-1:0] q_s
);

    localparam int unsigned CNT_W = $clog2(PAGE_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAGE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LD_ADDR,
        S_LD_CAP,
        S_LD_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [PAGE_W-1:0]   r_page;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_store;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_store   = (r_state == S_STORE);
    assign w_cnt_inc = CNT_W'(r_cnt + CNT_W'(1));

    // State and registered outputs; r_addr always tracks {page, cnt} while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_page      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_page     <= page;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_addr     <= {page, CNT_W'(0)};
                        r_in_ready <= ~dir;
                        r_state    <= dir ? S_LD_ADDR : S_STORE;
                    end
                end
                S_STORE: begin
                    if (in_valid) begin
                        if (r_cnt == LAST_WORD) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_addr     <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_addr <= {r_page, w_cnt_inc};
                        end
                    end
                end
                S_LD_ADDR: begin
                    r_state <= S_LD_CAP;
                end
                S_LD_CAP: begin
                    // q_s now reflects the address presented in S_LD_ADDR
                    r_out_data  <= q_s;
                    r_out_valid <= 1'b1;
                    r_state     <= S_LD_OUT;
                end
                S_LD_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_cnt == LAST_WORD) begin
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_addr  <= {r_page, w_cnt_inc};
                            r_state <= S_LD_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_addr      <= '0;
                end
            endcase
        end
    end

    // Store words are written in the same cycle they are accepted.
    assign tr_s      = w_store & in_valid;
    assign data_s    = w_store ? in_data : '0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign addr_s    = r_addr;

endmodule

// File: doc/disk_page_responder.md
Name: disk_page_responder

Overview:
- Disk-side end of the page-transfer protocol driven by the memory controller for STD (memory -> disk) and LDD (disk -> memory).
- Accepts one page request at a time and moves PAGE_WORDS words between a word stream and the disk port (data_s/addr_s/tr_s/q_s).
- Stream direction is fixed per request.
- Signals completion with a one-cycle done pulse.

Parameters:
- DATA_W, 16, word width; matches main memory and disk.
- ADDR_W, 15, disk word-address width.
- PAGE_WORDS, 1024, words per page; power of two, ≥ 2.
- PAGE_W, ADDR_W - log2(PAGE_WORDS), width of the page index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- dir  in  1  0 = store (stream -> disk), 1 = load (disk -> stream); sampled with req.
- page  in  PAGE_W  page index; sampled with req.
- busy  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- done  out  1  one-cycle pulse at the end of a transfer.
- in_valid  in  1  store word valid.
- in_data  in  DATA_W  store word.
- in_ready  out  1  responder accepts a store word.
- out_valid  out  1  load word valid.
- out_data  out  DATA_W  load word.
- out_ready  in  1  consumer accepts a load word.
- data_s  out  DATA_W  disk write data.
- addr_s  out  ADDR_W  disk address.
- tr_s  out  1  disk write enable.
- q_s  in  DATA_W  disk read data; synchronous, valid the cycle after addr_s is presented.

Behaviour:
- Reset, synchronous: state = IDLE; word counter and latched page/dir = 0; out_data = 0.
  - All outputs low/zero: busy, done, in_ready, out_valid, tr_s, addr_s, data_s.
- Reset mid-transfer: abort immediately to IDLE. No further disk writes. No done pulse. Words already written stay written.
- Disk address: addr_s = {page_latched, cnt}.
  - addr_s = 0 in IDLE and DONE.
  - cnt is log2(PAGE_WORDS) bits and never wraps into the page field.
- IDLE:
  - req=1 latches page and dir and clears cnt.
  - Next state is STORE if dir=0, LD_ADDR if dir=1.
  - req while not IDLE is ignored (no queueing).
- STORE:
  - busy=1, in_ready=1.
  - tr_s = in_valid and data_s = in_data, both combinational, so a word is written in the same cycle it is accepted.
  - On in_valid: if cnt = PAGE_WORDS-1, go to DONE; else cnt+1.
  - in_valid=0 stalls with tr_s=0.
- LD_ADDR: busy=1; present addr_s; tr_s=0; go to LD_CAP.
- LD_CAP:
  - Latch q_s into out_data.
  - Set out_valid=1, registered, so it is visible from the next cycle.
  - Go to LD_OUT.
- LD_OUT:
  - out_valid=1; out_data held stable until the handshake.
  - On out_ready: clear out_valid. If cnt = PAGE_WORDS-1, go to DONE; else cnt+1 and go to LD_ADDR.
  - Load throughput is one word per 3 cycles minimum.
- DONE: done=1, busy=1 for one cycle, then IDLE. A req in this cycle is ignored.
- data_s = 0 and tr_s = 0 in every state except STORE.
- Outputs are functions of state only, except tr_s/data_s in STORE, which follow in_valid/in_data.

Test Plan:
1. PAGE_WORDS=4. Store page 3 with in_valid always high, words 0xA000..0xA003.
   - Response: tr_s high 4 consecutive cycles at addr_s 12..15 with those data.
   - done pulses exactly one cycle after the last write; busy falls after done.
2. Load page 2 after preloading disk 8..11 = 0x0011, 0x0022, 0x8000, 0xFFFF, out_ready=1.
   - Response: out_data sequence matches exactly, one out_valid handshake per word, tr_s never asserted.
   - done pulses once.
3. Load with out_ready held low for 5 cycles on word 1.
   - Response: out_valid and out_data stay at 0x0022 throughout; cnt does not advance; remaining words unaffected.
4. Store with in_valid gaps (pattern 1,0,0,1,1,0,1).
   - Response: exactly 4 writes, each at consecutive addresses; no tr_s during gaps.
5. Assert req (dir=1, page=0) during an active store of page 1.
   - Response: ignored; store completes to addresses 4..7; no load starts.
6. Assert reset after 2 store words.
   - Response: next cycle busy=0, tr_s=0, state IDLE, no done.
   - A new request then transfers a full page from cnt=0.
